vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//   Video timing generator clocked by the 25 MHz pixel clock from the PLL stage; consumes its
//   clock and lock outputs. Holds off until the PLL is locked and settled, then produces
//   640x480@60 sync, data-enable and pixel coordinates for the invaders renderer.
//   Drops back to idle on loss of lock.
// PARAMETERS
//   H_ACTIVE    640  visible pixels per line
//   H_FP         16  horizontal front porch (pixels)
//   H_SYNC       96  hsync width (pixels)
//   H_BP         48  horizontal back porch (pixels)
//   V_ACTIVE    480  visible lines per frame
//   V_FP         10  vertical front porch (lines)
//   V_SYNC        2  vsync width (lines)
//   V_BP         33  vertical back porch (lines)
//   HS_POL        0  hsync active level (0 = active-low)
//   VS_POL        0  vsync active level
//   LOCK_DELAY   16  cycles of stable synced lock before RUN; 0 = enter RUN directly
// PORTS
//   clock        in   1   pixel clock (PLL clock_out)
//   reset_n      in   1   asynchronous reset, active-low
//   pll_locked   in   1   PLL lock, asynchronous to clock; synchronized internally
//   ready        out  1   1 while in RUN
//   x            out  HW  horizontal position, HW = $clog2(H_TOTAL) (10 at defaults)
//   y            out  VW  vertical position, VW = $clog2(V_TOTAL) (10 at defaults)
//   de           out  1   1 when x<H_ACTIVE && y<V_ACTIVE
//   hsync        out  1   horizontal sync, polarity HS_POL
//   vsync        out  1   vertical sync, polarity VS_POL
//   frame_start  out  1   one-cycle pulse at (0,0)
// BEHAVIOUR
// - H_TOTAL = 800 and V_TOTAL = 525 at defaults; each is the sum of its four fields.
// - All outputs are registered and mutually coherent: on any cycle, de, hsync, vsync and
//   frame_start describe the position shown on x/y.
// - Reset (async assert, sync release): state WAIT_LOCK, x=y=0, de=0, frame_start=0, ready=0.
//   hsync=~HS_POL and vsync=~VS_POL (inactive). Both lock sync flops are cleared.
// - Lock sync: 2-FF synchronizer, so lk_s lags pll_locked by 2 cycles.
// - FSM:
//     WAIT_LOCK: counters held 0, outputs inactive. If lk_s=1: go to SETTLE with settle cnt=0,
//       or go directly to RUN when LOCK_DELAY=0.
//     SETTLE: cnt increments each cycle. If lk_s=0, return to WAIT_LOCK.
//       If cnt==LOCK_DELAY-1, go to RUN.
//     RUN: ready=1; x advances each cycle. If lk_s=0, go to WAIT_LOCK next cycle: counters
//       reset to 0, outputs inactive, frame_start=0. No partial-frame completion.
// - First RUN cycle presents x=0, y=0, de=1, frame_start=1.
// - Counters: x wraps H_TOTAL-1 -> 0. y increments only when x wraps; y wraps V_TOTAL-1 -> 0.
//   Simultaneous wrap of x and y yields (0,0) with frame_start=1.
// - hsync is active for H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (656..751 at defaults).
// - vsync is active for V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (490..491), across whole lines.
// - Counters are unsigned; no value outside 0..TOTAL-1 is ever presented.
// STRUCTURE
//   Package vga_timing_pkg holds:
//     - 640x480@60 default localparams
//     - H_TOTAL/V_TOTAL computation functions
//     - state enum {WAIT_LOCK, SETTLE, RUN}
//   Sub-module lock_sync: 2-FF synchronizer with async active-low clear.
//   The FSM, counters and output decode live in this module.
// TESTING
//   1. Reset, pll_locked=0 for 100 cycles -> ready=0, de=0, hsync=vsync=1, x=y=0 throughout.
//   2. pll_locked rises at cycle t -> ready rises at t+2+16+1 (+/-0 exact); first RUN cycle
//      shows x=0, y=0, frame_start=1.
//   3. One full line -> de high for exactly 640 cycles; hsync low for x=656..751 (96 cycles);
//      x=799 -> 0 with y incrementing.
//   4. Two full frames -> frame_start period 420000 cycles; vsync low for exactly 2 lines
//      (1600 cycles) starting at y=490,x=0.
//   5. pll_locked drops during RUN at y=300 -> within 3 cycles ready=0, de=0, x=y=0;
//      relock restarts at (0,0) after settling.
//   6. Lock glitch lasting 5 cycles during SETTLE -> FSM returns to WAIT_LOCK and the full
//      16-cycle delay restarts. reset_n asserted mid-line -> all outputs take reset values
//      immediately (async).

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing defaults, line/frame total helper and FSM state type
// for the VGA timing generator.
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE   = 640;
    localparam int DEF_H_FP       = 16;
    localparam int DEF_H_SYNC     = 96;
    localparam int DEF_H_BP       = 48;
    localparam int DEF_V_ACTIVE   = 480;
    localparam int DEF_V_FP       = 10;
    localparam int DEF_V_SYNC     = 2;
    localparam int DEF_V_BP       = 33;
    localparam int DEF_LOCK_DELAY = 16;

    // The horizontal and vertical totals are both the sum of their four fields.
    function automatic int line_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } state_t;

endpackage

// File: rtl/vga_timing_gen_lock_sync.sv
// Two-flop synchronizer that brings the PLL lock into the pixel clock domain;
// both flops clear on reset so a stale lock never leaks through.
module lock_sync (
    input  logic clock,
    input  logic reset_n,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta     <= 1'b0;
            sync_out <= 1'b0;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: waits for a settled PLL lock, then produces registered
// sync, data-enable, frame pulse and pixel coordinates that always agree.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE   = DEF_H_ACTIVE,
    parameter int   H_FP       = DEF_H_FP,
    parameter int   H_SYNC     = DEF_H_SYNC,
    parameter int   H_BP       = DEF_H_BP,
    parameter int   V_ACTIVE   = DEF_V_ACTIVE,
    parameter int   V_FP       = DEF_V_FP,
    parameter int   V_SYNC     = DEF_V_SYNC,
    parameter int   V_BP       = DEF_V_BP,
    parameter logic HS_POL     = 1'b0,
    parameter logic VS_POL     = 1'b0,
    parameter int   LOCK_DELAY = DEF_LOCK_DELAY,
    localparam int  H_TOTAL    = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int  V_TOTAL    = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int  HW         = $clog2(H_TOTAL),
    localparam int  VW         = $clog2(V_TOTAL)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          pll_locked,
    output logic          ready,
    output logic [HW-1:0] x,
    output logic [VW-1:0] y,
    output logic          de,
    output logic          hsync,
    output logic          vsync,
    output logic          frame_start
);

    localparam int CW = (LOCK_DELAY > 1) ? $clog2(LOCK_DELAY) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((LOCK_DELAY > 0) ? LOCK_DELAY - 1 : 0);
    localparam logic [HW-1:0] X_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] Y_LAST   = VW'(V_TOTAL - 1);
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_STOP  = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_STOP  = V_ACTIVE + V_FP + V_SYNC;

    state_t        state;
    logic [CW-1:0] settle_cnt;
    logic          lk_s;

    logic [HW-1:0] next_x;
    logic [VW-1:0] next_y;
    logic          next_de;
    logic          next_hs_act;
    logic          next_vs_act;
    logic          next_fs;

    lock_sync u_lock_sync (
        .clock    (clock),
        .reset_n  (reset_n),
        .async_in (pll_locked),
        .sync_out (lk_s)
    );

    // Outputs are decoded from the position about to be loaded into x/y, so the
    // registered flags always describe the coordinates shown alongside them.
    always_comb begin
        next_x = '0;
        next_y = y;
        if (x == X_LAST) begin
            next_x = '0;
            next_y = (y == Y_LAST) ? '0 : y + 1'b1;
        end else begin
            next_x = x + 1'b1;
        end
        next_de     = (int'(next_x) < H_ACTIVE) && (int'(next_y) < V_ACTIVE);
        next_hs_act = (int'(next_x) >= HS_START) && (int'(next_x) < HS_STOP);
        next_vs_act = (int'(next_y) >= VS_START) && (int'(next_y) < VS_STOP);
        next_fs     = (next_x == '0) && (next_y == '0);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= WAIT_LOCK;
            settle_cnt  <= '0;
            ready       <= 1'b0;
            x           <= '0;
            y           <= '0;
            de          <= 1'b0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            frame_start <= 1'b0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    settle_cnt  <= '0;
                    x           <= '0;
                    y           <= '0;
                    de          <= 1'b0;
                    hsync       <= ~HS_POL;
                    vsync       <= ~VS_POL;
                    frame_start <= 1'b0;
                    ready       <= 1'b0;
                    if (lk_s) begin
                        if (LOCK_DELAY == 0) begin
                            state       <= RUN;
                            ready       <= 1'b1;
                            de          <= 1'b1;
                            frame_start <= 1'b1;
                        end else begin
                            state <= SETTLE;
                        end
                    end
                end

                SETTLE: begin
                    if (!lk_s) begin
                        state      <= WAIT_LOCK;
                        settle_cnt <= '0;
                    end else if (settle_cnt == CNT_LAST) begin
                        state       <= RUN;
                        settle_cnt  <= '0;
                        ready       <= 1'b1;
                        x           <= '0;
                        y           <= '0;
                        de          <= 1'b1;
                        hsync       <= ~HS_POL;
                        vsync       <= ~VS_POL;
                        frame_start <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end

                RUN: begin
                    // Losing lock abandons the frame outright rather than finishing it.
                    if (!lk_s) begin
                        state       <= WAIT_LOCK;
                        ready       <= 1'b0;
                        x           <= '0;
                        y           <= '0;
                        de          <= 1'b0;
                        hsync       <= ~HS_POL;
                        vsync       <= ~VS_POL;
                        frame_start <= 1'b0;
                    end else begin
                        ready       <= 1'b1;
                        x           <= next_x;
                        y           <= next_y;
                        de          <= next_de;
                        hsync       <= next_hs_act ? HS_POL : ~HS_POL;
                        vsync       <= next_vs_act ? VS_POL : ~VS_POL;
                        frame_start <= next_fs;
                    end
                end

                default: begin
                    state <= WAIT_LOCK;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen; the vertical geometry is shortened to a
// 30-line frame so whole-frame checks stay quick, horizontal timing is default.
module tb_vga_timing_gen;

    localparam int V_ACTIVE = 20;
    localparam int V_FP     = 3;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 5;
    localparam int H_TOTAL  = 800;
    localparam int V_TOTAL  = 30;
    localparam int LATENCY  = 2 + 16 + 1;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       pll_locked;
    logic       ready;
    logic [9:0] x;
    logic [4:0] y;
    logic       de;
    logic       hsync;
    logic       vsync;
    logic       frame_start;

    int tests_run = 0;
    int tests_failed = 0;

    always #20 clock = ~clock;

    vga_timing_gen #(
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .pll_locked  (pll_locked),
        .ready       (ready),
        .x           (x),
        .y           (y),
        .de          (de),
        .hsync       (hsync),
        .vsync       (vsync),
        .frame_start (frame_start)
    );

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!ready && n < 60);
    endtask

    task automatic test_reset();
        int bad;
        reset_n    = 1'b0;
        pll_locked = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            tests_run++;
            if ({ready, de, hsync, vsync, frame_start} !== 5'b00110 || x !== 10'd0 || y !== 5'd0) begin
                tests_failed++;
                $display("[TB] FAIL idle cycle %0d: ready=%b de=%b hs=%b vs=%b fs=%b x=%0d y=%0d, expected 0 0 1 1 0 0 0",
                         i, ready, de, hsync, vsync, frame_start, x, y);
            end
        end
    endtask

    task automatic test_lock_latency();
        int n;
        pll_locked = 1'b1;
        wait_ready(n);
        tests_run++;
        if (n !== LATENCY) begin
            tests_failed++;
            $display("[TB] FAIL lock latency: got %0d cycles, expected %0d", n, LATENCY);
        end
        tests_run++;
        if (x !== 10'd0 || y !== 5'd0 || frame_start !== 1'b1 || de !== 1'b1 || hsync !== 1'b1 || vsync !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL first run cycle: x=%0d y=%0d fs=%b de=%b hs=%b vs=%b, expected 0 0 1 1 1 1",
                     x, y, frame_start, de, hsync, vsync);
        end
    endtask

    task automatic test_line();
        int x_err, de_cnt, hs_cnt, hs_first, hs_last;
        x_err = 0; de_cnt = 0; hs_cnt = 0; hs_first = -1; hs_last = -1;
        for (int i = 0; i < H_TOTAL; i++) begin
            if (x !== 10'(i) || y !== 5'd0) x_err++;
            if (de) de_cnt++;
            if (!hsync) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = i;
                hs_last = i;
            end
            step();
        end
        tests_run++;
        if (x_err !== 0) begin
            tests_failed++;
            $display("[TB] FAIL line x sequence: %0d positions wrong, expected 0", x_err);
        end
        tests_run++;
        if (de_cnt !== 640) begin
            tests_failed++;
            $display("[TB] FAIL line de count: got %0d, expected 640", de_cnt);
        end
        tests_run++;
        if (hs_cnt !== 96 || hs_first !== 656 || hs_last !== 751) begin
            tests_failed++;
            $display("[TB] FAIL hsync window: count=%0d first=%0d last=%0d, expected 96 656 751",
                     hs_cnt, hs_first, hs_last);
        end
        tests_run++;
        if (x !== 10'd0 || y !== 5'd1 || de !== 1'b1 || frame_start !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL line wrap: x=%0d y=%0d de=%b fs=%b, expected 0 1 1 0", x, y, de, frame_start);
        end
    endtask

    task automatic test_frames();
        int n, period, vs_cnt, de_cnt, vs_x, vs_y, range_err;
        n = 0;
        while (!frame_start && n < 30000) begin
            step();
            n++;
        end
        tests_run++;
        if (!frame_start) begin
            tests_failed++;
            $display("[TB] FAIL frame_start wait: got none in %0d cycles, expected one", n);
        end
        period = 0; vs_cnt = 0; de_cnt = 0; vs_x = -1; vs_y = -1; range_err = 0;
        do begin
            if (int'(x) >= H_TOTAL || int'(y) >= V_TOTAL) range_err++;
            if (de) de_cnt++;
            if (!vsync) begin
                if (vs_cnt == 0) begin
                    vs_x = int'(x);
                    vs_y = int'(y);
                end
                vs_cnt++;
            end
            step();
            period++;
        end while (!frame_start && period < 30000);
        tests_run++;
        if (period !== H_TOTAL * V_TOTAL) begin
            tests_failed++;
            $display("[TB] FAIL frame period: got %0d, expected %0d", period, H_TOTAL * V_TOTAL);
        end
        tests_run++;
        if (vs_cnt !== 1600 || vs_y !== 23 || vs_x !== 0) begin
            tests_failed++;
            $display("[TB] FAIL vsync window: count=%0d start y=%0d x=%0d, expected 1600 23 0", vs_cnt, vs_y, vs_x);
        end
        tests_run++;
        if (de_cnt !== 640 * V_ACTIVE || range_err !== 0) begin
            tests_failed++;
            $display("[TB] FAIL frame de/range: de=%0d range_err=%0d, expected %0d 0", de_cnt, range_err, 640 * V_ACTIVE);
        end
        tests_run++;
        if (x !== 10'd0 || y !== 5'd0 || de !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL frame wrap: x=%0d y=%0d de=%b, expected 0 0 1", x, y, de);
        end
    endtask

    task automatic test_lock_drop();
        int n;
        n = 0;
        while (!(y == 5'd15 && x == 10'd100) && n < 30000) begin
            step();
            n++;
        end
        tests_run++;
        if (y !== 5'd15 || x !== 10'd100) begin
            tests_failed++;
            $display("[TB] FAIL reach y=15: got x=%0d y=%0d, expected 100 15", x, y);
        end
        pll_locked = 1'b0;
        repeat (3) step();
        tests_run++;
        if ({ready, de, hsync, vsync, frame_start} !== 5'b00110 || x !== 10'd0 || y !== 5'd0) begin
            tests_failed++;
            $display("[TB] FAIL lock drop: ready=%b de=%b hs=%b vs=%b fs=%b x=%0d y=%0d, expected 0 0 1 1 0 0 0",
                     ready, de, hsync, vsync, frame_start, x, y);
        end
        repeat (5) step();
        pll_locked = 1'b1;
        wait_ready(n);
        tests_run++;
        if (n !== LATENCY || x !== 10'd0 || y !== 5'd0 || frame_start !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL relock: latency=%0d x=%0d y=%0d fs=%b, expected %0d 0 0 1",
                     n, x, y, frame_start, LATENCY);
        end
    endtask

    task automatic test_settle_glitch();
        int n, early;
        pll_locked = 1'b0;
        repeat (6) step();
        early = 0;
        pll_locked = 1'b1;
        repeat (8) begin
            step();
            if (ready) early++;
        end
        pll_locked = 1'b0;
        repeat (5) begin
            step();
            if (ready) early++;
        end
        tests_run++;
        if (early !== 0) begin
            tests_failed++;
            $display("[TB] FAIL glitch ready: high on %0d cycles, expected 0", early);
        end
        pll_locked = 1'b1;
        wait_ready(n);
        tests_run++;
        if (n !== LATENCY || x !== 10'd0 || y !== 5'd0) begin
            tests_failed++;
            $display("[TB] FAIL glitch restart: latency=%0d x=%0d y=%0d, expected %0d 0 0", n, x, y, LATENCY);
        end
    endtask

    task automatic test_async_reset();
        int n;
        n = 0;
        while (x != 10'd300 && n < 2000) begin
            step();
            n++;
        end
        tests_run++;
        if (x !== 10'd300 || de !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL mid-line setup: x=%0d de=%b, expected 300 1", x, de);
        end
        #5 reset_n = 1'b0;
        #1;
        tests_run++;
        if ({ready, de, hsync, vsync, frame_start} !== 5'b00110 || x !== 10'd0 || y !== 5'd0) begin
            tests_failed++;
            $display("[TB] FAIL async reset: ready=%b de=%b hs=%b vs=%b fs=%b x=%0d y=%0d, expected 0 0 1 1 0 0 0",
                     ready, de, hsync, vsync, frame_start, x, y);
        end
        repeat (3) step();
        reset_n = 1'b1;
        wait_ready(n);
        tests_run++;
        if (n !== LATENCY) begin
            tests_failed++;
            $display("[TB] FAIL post-reset latency: got %0d, expected %0d", n, LATENCY);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        pll_locked = 1'b0;
        test_reset();
        test_lock_latency();
        test_line();
        test_frames();
        test_lock_drop();
        test_settle_glitch();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
